// File: rtl/sw_debounce_detect_pkg.sv
// Shared defaults for the switch/button conditioning block.
// DEF_DEBOUNCE_CYC is 10 ms at 50 MHz (DE1-SoC CLOCK_50); DEF_CNT_W is wide enough to hold it.
package sw_debounce_detect_pkg;

   localparam int unsigned DEF_WIDTH        = 3;
   localparam int unsigned DEF_DEBOUNCE_CYC = 500000;
   localparam int unsigned DEF_CNT_W        = 19;

endpackage : sw_debounce_detect_pkg

// File: rtl/sw_debounce_detect_debounce_bit.sv
// Single-bit conditioner: 2-FF synchroniser, hold-time debounce counter,
// debounced level and one-cycle rise/fall pulses.
//  clk     in  system clock, rising edge
//  rst_n   in  asynchronous active-low reset
//  raw     in  asynchronous switch/button level
//  stable  out debounced level
//  rise    out 1-cycle pulse on stable 0->1
//  fall    out 1-cycle pulse on stable 1->0
module sw_debounce_detect_debounce_bit
   import sw_debounce_detect_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int unsigned CNT_W        = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic stable,
   output logic rise,
   output logic fall
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             stable_q, stable_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next-state: count consecutive cycles the synchronised level differs from stable.
   always_comb begin
      sync1_d  = raw;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            // Level held long enough: accept it and restart the count from 0.
            stable_d = sync2_q;
            rise_d   = sync2_q;
            fall_d   = ~sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable = stable_q;
   assign rise   = rise_q;
   assign fall   = fall_q;

endmodule : sw_debounce_detect_debounce_bit

// File: rtl/sw_debounce_detect.sv
// Conditions raw slide-switch / pushbutton levels: per-bit sync + debounce + edge detect,
// plus a registered all-ones detect with a one-cycle arm pulse.
//  CLOCK_50    in  system clock, rising edge
//  resetn      in  asynchronous active-low reset
//  raw_in      in  [WIDTH] asynchronous switch/button levels
//  stable      out [WIDTH] debounced levels
//  rise        out [WIDTH] 1-cycle pulse per bit on stable 0->1
//  fall        out [WIDTH] 1-cycle pulse per bit on stable 1->0
//  all_on      out registered &stable
//  all_on_arm  out 1-cycle pulse on all_on 0->1
module sw_debounce_detect
   import sw_debounce_detect_pkg::*;
#(
   parameter int unsigned WIDTH        = DEF_WIDTH,
   parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int unsigned CNT_W        = DEF_CNT_W
) (
   input  logic             CLOCK_50,
   input  logic             resetn,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] stable,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             all_on,
   output logic             all_on_arm
);

   logic all_on_q, all_on_d;
   logic all_on_arm_q, all_on_arm_d;

   // One independent conditioner per input bit.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sw_debounce_detect_debounce_bit #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .CNT_W        (CNT_W)
      ) u_bit (
         .clk    (CLOCK_50),
         .rst_n  (resetn),
         .raw    (raw_in[i]),
         .stable (stable[i]),
         .rise   (rise[i]),
         .fall   (fall[i])
      );
   end

   // Arm fires only when all_on is about to go 0->1, so a held all-ones gives one pulse.
   always_comb begin
      all_on_d     = &stable;
      all_on_arm_d = all_on_d & ~all_on_q;
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         all_on_q     <= 1'b0;
         all_on_arm_q <= 1'b0;
      end else begin
         all_on_q     <= all_on_d;
         all_on_arm_q <= all_on_arm_d;
      end
   end

   assign all_on     = all_on_q;
   assign all_on_arm = all_on_arm_q;

endmodule : sw_debounce_detect
